instruction_fetch_tag: RTL
==========================

INSTRUCTION_FETCH_TAG -- requirements
Module: instruction_fetch_tag

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter: ICACHE_NUM_WAYS, default 4, taken from the shared package.
REQ-003 Parameter: ICACHE_NUM_SETS, default 64; line size 64 B; address split tag[31:12], set[11:6], offset[5:0].
REQ-004 clk  in  1  core clock.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 stall  in  1  downstream hold; freezes PC and output registers.
REQ-007 flush  in  1  kill in-flight fetch; output invalid next cycle.
REQ-008 pc_redirect_en  in  1  branch/exception redirect request.
REQ-009 pc_redirect  in  32  redirect target, word-aligned.
REQ-010 ifd_ift_inf  in  ifd_ift_inf_t  refill update from data stage: update_tag_en[WAYS], update_tag[19:0], update_set[5:0].
REQ-011 ift_ifd_inf  out  ift_ifd_inf_t  fetched_pc[31:0], tags_read[WAYS][19:0], valid_bits[WAYS], ctrl.instruction_valid.

Function
REQ-012 PC register advances by 4 each cycle when stall=0 and no redirect applies; 32-bit wrap from FFFF_FFFC to 0000_0000.
REQ-013 Tag read uses set(PC); tags_read/valid_bits/fetched_pc registered together, 1-cycle latency from PC to output.
REQ-014 stall=1 holds PC, fetched_pc, tags_read, valid_bits and instruction_valid unchanged.
REQ-015 FSM states RUN, REDIRECT_PENDING; reset state RUN.
REQ-016 RUN, pc_redirect_en=1, stall=0: PC <= pc_redirect next edge; output instruction_valid=0 for that cycle.
REQ-017 RUN, pc_redirect_en=1, stall=1: target latched, go REDIRECT_PENDING.
REQ-018 REDIRECT_PENDING, stall=0: PC <= latched target, instruction_valid=0, return RUN; a newer pc_redirect_en overwrites the latched target.
REQ-019 flush=1 forces instruction_valid=0 on next edge regardless of stall; PC unaffected unless redirect also asserted.
REQ-020 Tag update: each way with update_tag_en[w]=1 writes update_tag at update_set and sets valid[update_set][w]; accepted even while stall=1.
REQ-021 Write-first bypass: read of same set in update cycle returns new tag and valid bit.
REQ-022 Valid bits stored in flops; tag arrays in synchronous-read RAM.
REQ-023 Simultaneous redirect and tag update: both take effect; neither delayed.

Reset
REQ-024 rst=0: PC=RESET_PC, FSM=RUN, all valid bits=0, fetched_pc=0, tags_read=0, valid_bits=0, instruction_valid=0.
REQ-025 First cycle after rst release: outputs fetched_pc=RESET_PC with instruction_valid=1 on second edge.
REQ-026 Reset mid-redirect discards latched target; tag RAM contents undefined but masked by cleared valid bits.

Structure
REQ-027 ift_ifd_inf_t, ifd_ift_inf_t, ICACHE_NUM_WAYS, ICACHE_NUM_SETS, ICACHE_TAG_BITS and address-split constants in the shared core package.
REQ-028 One sub-module icache_tag_ram (one instance per way, 64x20, synchronous read, write-first).

Verification
REQ-029 Release reset, stall=0 -> fetched_pc 0,4,8,... one per cycle, valid_bits=0, instruction_valid=1.
REQ-030 Update way 2 set 0 tag 20'h00000, then refetch PC 0 -> valid_bits=4'b0100, tags_read[2]=0.
REQ-031 PC walks 0x00..0x3C then 0x40 -> set changes to 1, valid_bits=0 at 0x40.
REQ-032 Redirect to 0x1000 during stall=1 for 3 cycles -> PC held; 0x1000 emitted first cycle after stall drops.
REQ-033 flush=1 with stall=1 -> instruction_valid=0 next cycle, fetched_pc unchanged.
REQ-034 Assert rst mid-run after updates -> all valid_bits 0, fetched_pc restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_tag_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_tag_pkg                                                |
// | Shared I-cache geometry and the fetch-tag / fetch-data stage interfaces.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package instruction_fetch_tag_pkg;

  localparam int ICACHE_NUM_WAYS    = 4;
  localparam int ICACHE_NUM_SETS    = 64;
  localparam int ICACHE_LINE_BYTES  = 64;
  localparam int ICACHE_TAG_BITS    = 20;
  localparam int ICACHE_SET_BITS    = 6;
  localparam int ICACHE_OFFSET_BITS = 6;

  // Address split: tag[31:12], set[11:6], offset[5:0]
  localparam int ADDR_SET_LSB = ICACHE_OFFSET_BITS;
  localparam int ADDR_TAG_LSB = ICACHE_OFFSET_BITS + ICACHE_SET_BITS;

  typedef struct packed {
    logic instruction_valid;
  } ift_ctrl_t;

  typedef struct packed {
    logic [31:0]                                       fetched_pc;
    logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_BITS-1:0]   tags_read;
    logic [ICACHE_NUM_WAYS-1:0]                        valid_bits;
    ift_ctrl_t                                         ctrl;
  } ift_ifd_inf_t;

  typedef struct packed {
    logic [ICACHE_NUM_WAYS-1:0]  update_tag_en;
    logic [ICACHE_TAG_BITS-1:0]  update_tag;
    logic [ICACHE_SET_BITS-1:0]  update_set;
  } ifd_ift_inf_t;

endpackage
`default_nettype wire

// File: rtl/instruction_fetch_tag_tag_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | icache_tag_ram                                                           |
// | One way of I-cache tags: synchronous read, write-first on same address.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module icache_tag_ram
  import instruction_fetch_tag_pkg::*;
#(
  parameter int DEPTH  = ICACHE_NUM_SETS,
  parameter int WIDTH  = ICACHE_TAG_BITS,
  parameter int ADDR_W = ICACHE_SET_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Only the read register is reset; array contents are masked by valid bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (re) begin
      r_rdata <= (we && (waddr == raddr)) ? wdata : r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_tag.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instruction_fetch_tag                                                    |
// | PC generation, redirect handling and I-cache tag/valid lookup stage.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module instruction_fetch_tag #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int          ICACHE_NUM_WAYS = instruction_fetch_tag_pkg::ICACHE_NUM_WAYS,
  parameter int          ICACHE_NUM_SETS = instruction_fetch_tag_pkg::ICACHE_NUM_SETS
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      stall,
  input  logic                                      flush,
  input  logic                                      pc_redirect_en,
  input  logic [31:0]                               pc_redirect,
  input  instruction_fetch_tag_pkg::ifd_ift_inf_t   ifd_ift_inf,
  output instruction_fetch_tag_pkg::ift_ifd_inf_t   ift_ifd_inf
);

  import instruction_fetch_tag_pkg::*;

  localparam logic [0:0] c_run              = 1'b0;
  localparam logic [0:0] c_redirect_pending = 1'b1;

  logic [0:0]                 r_state;
  logic [31:0]                r_pc;
  logic [31:0]                r_target;
  logic [ICACHE_NUM_WAYS-1:0] r_valid [0:ICACHE_NUM_SETS-1];
  logic [31:0]                r_fetched_pc;
  logic [ICACHE_NUM_WAYS-1:0] r_valid_bits;
  logic                       r_instr_valid;

  logic [ICACHE_SET_BITS-1:0]                      w_rd_set;
  logic [ICACHE_NUM_WAYS-1:0]                      w_valid_rd;
  logic [ICACHE_NUM_WAYS-1:0][ICACHE_TAG_BITS-1:0] w_tags;
  logic                                            w_redirect_now;
  logic [31:0]                                     w_redirect_pc;

  assign w_rd_set = r_pc[ADDR_SET_LSB +: ICACHE_SET_BITS];

  // A live redirect request takes priority over an older latched target.
  always_comb begin
    w_redirect_now = 1'b0;
    w_redirect_pc  = pc_redirect;
    if (!stall) begin
      if (pc_redirect_en) begin
        w_redirect_now = 1'b1;
        w_redirect_pc  = pc_redirect;
      end else if (r_state == c_redirect_pending) begin
        w_redirect_now = 1'b1;
        w_redirect_pc  = r_target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= c_run;
      r_pc     <= RESET_PC;
      r_target <= '0;
    end else if (stall) begin
      if (pc_redirect_en) begin
        r_target <= pc_redirect;
        r_state  <= c_redirect_pending;
      end
    end else begin
      r_state <= c_run;
      r_pc    <= w_redirect_now ? w_redirect_pc : r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 0; s < ICACHE_NUM_SETS; s++) r_valid[s] <= '0;
    end else begin
      for (int w = 0; w < ICACHE_NUM_WAYS; w++) begin
        if (ifd_ift_inf.update_tag_en[w]) r_valid[ifd_ift_inf.update_set][w] <= 1'b1;
      end
    end
  end

  for (genvar w = 0; w < ICACHE_NUM_WAYS; w++) begin : g_way
    assign w_valid_rd[w] = r_valid[w_rd_set][w] |
                           (ifd_ift_inf.update_tag_en[w] && (ifd_ift_inf.update_set == w_rd_set));

    icache_tag_ram #(
      .DEPTH  (ICACHE_NUM_SETS),
      .WIDTH  (ICACHE_TAG_BITS),
      .ADDR_W (ICACHE_SET_BITS)
    ) u_tag_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (ifd_ift_inf.update_tag_en[w]),
      .waddr (ifd_ift_inf.update_set),
      .wdata (ifd_ift_inf.update_tag),
      .re    (!stall),
      .raddr (w_rd_set),
      .rdata (w_tags[w])
    );
  end

  // Flush clears validity even while stalled; everything else holds on stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetched_pc  <= '0;
      r_valid_bits  <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      if (!stall) begin
        r_fetched_pc <= r_pc;
        r_valid_bits <= w_valid_rd;
      end
      if (flush || w_redirect_now) begin
        r_instr_valid <= 1'b0;
      end else if (!stall) begin
        r_instr_valid <= 1'b1;
      end
    end
  end

  assign ift_ifd_inf.fetched_pc             = r_fetched_pc;
  assign ift_ifd_inf.tags_read              = w_tags;
  assign ift_ifd_inf.valid_bits             = r_valid_bits;
  assign ift_ifd_inf.ctrl.instruction_valid = r_instr_valid;

endmodule
`default_nettype wire
